// File: rtl/pmod_io_ctrl.sv
// PMOD button/LED front end: synchronised, debounced buttons with edge pulses
// and per-channel PWM LEDs, all pins routed through tristate buffers.

module tristate_buffer (
  input  logic oe,
  input  logic dout,
  output logic din,
  inout  wire  pin
);

  assign pin = oe ? dout : 1'bz;
  assign din = pin;

endmodule

module pmod_io_ctrl #(
  parameter int                    NUM_BTNS         = 3,
  parameter int                    NUM_LEDS         = 5,
  parameter logic [3*NUM_BTNS-1:0] BTN_MAP          = {3'd7, 3'd3, 3'd6},
  parameter logic [3*NUM_LEDS-1:0] LED_MAP          = {3'd4, 3'd5, 3'd2,
                                                       3'd1, 3'd0},
  parameter bit                    DEBOUNCE_BUTTONS = 1'b1,
  parameter int                    DEBOUNCE_CYCLES  = 65536,
  parameter bit                    BTN_ACTIVE_LOW   = 1'b0,
  parameter int                    PWM_BITS         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  inout  wire  [7:0]                   pmod,
  input  logic [NUM_LEDS*PWM_BITS-1:0] led_level,
  output logic [NUM_BTNS-1:0]          btns,
  output logic [NUM_BTNS-1:0]          btn_press,
  output logic [NUM_BTNS-1:0]          btn_release
);

  localparam logic [PWM_BITS-1:0] PMAX = '1;

  logic [7:0] pin_oe;
  logic [7:0] pin_do;
  logic [7:0] pin_di;

  logic [NUM_BTNS-1:0] pin_btn;
  logic [NUM_BTNS-1:0] sync1;
  logic [NUM_BTNS-1:0] sync2;
  logic [NUM_BTNS-1:0] btn_nxt;

  logic [PWM_BITS-1:0]                pwm_cnt;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] shadow;
  logic [NUM_LEDS-1:0]                led_q;

  for (genvar g = 0; g < 8; g++) begin : g_pin
    tristate_buffer u_tbuf (
      .oe   (pin_oe[g]),
      .dout (pin_do[g]),
      .din  (pin_di[g]),
      .pin  (pmod[g])
    );
  end

  always_comb begin
    pin_oe = '0;
    pin_do = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      pin_oe[LED_MAP[3*i +: 3]] = 1'b1;
      pin_do[LED_MAP[3*i +: 3]] = led_q[i];
    end
  end

  // Mask-and-reduce keeps every pin input in use whatever the map.
  always_comb begin
    pin_btn = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      pin_btn[i] = |(pin_di & (8'd1 << BTN_MAP[3*i +: 3]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_btn ^ {NUM_BTNS{BTN_ACTIVE_LOW}};
      sync2 <= sync1;
    end
  end

  if (DEBOUNCE_BUTTONS) begin : g_db
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
      logic [CW-1:0] cnt;
      logic          diff;
      logic          hit;

      assign diff       = sync2[i] ^ btns[i];
      assign hit        = (cnt == CMAX);
      assign btn_nxt[i] = btns[i] ^ (diff & hit);

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt <= '0;
        end else if (!diff || hit) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end else begin : g_nodb
    assign btn_nxt = sync2;
  end

  // Pulses come from the next state so they coincide with the btns change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btns        <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      btns        <= btn_nxt;
      btn_press   <= btn_nxt & ~btns;
      btn_release <= ~btn_nxt & btns;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt <= '0;
      shadow  <= '0;
      led_q   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == PMAX) begin
        shadow <= led_level;
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
        led_q[i] <= (pwm_cnt < shadow[i]) || (shadow[i] == PMAX);
      end
    end
  end

endmodule
